// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID pipeline register
// Optional fetch/discard performance counters: define IF_STAGE_PERF_CNT_EN.
module if_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_if,
  input  logic            stall_id,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc_plus4
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_discarded
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, BUF} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            discard_q, discard_d;
  logic [31:0]     buf_q, buf_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;

  logic            issue;
  logic            deliver;
  logic [31:0]     deliver_instr;
  logic [XLEN-1:0] fetch_addr;
  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    discard_d     = discard_q;
    buf_d         = buf_q;
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_instr_d    = id_instr_q;
    id_pc_plus4_d = id_pc_plus4_q;
    issue         = 1'b0;
    deliver       = 1'b0;
    deliver_instr = buf_q;
    fetch_addr    = pc_q;

    if (redirect_valid) begin
      // Redirect beats both stalls; an in-flight response not arriving now must be discarded later.
      pc_d       = redirect_pc & ~XLEN'(3);
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
      if (state_q == WAIT && !imem_rvalid) begin
        discard_d = 1'b1;
        state_d   = WAIT;
      end else begin
        discard_d = 1'b0;
        state_d   = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!stall_if) begin
            issue   = 1'b1;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = IDLE;
            end else if (!stall_id) begin
              deliver       = 1'b1;
              deliver_instr = imem_rdata;
            end else begin
              buf_d   = imem_rdata;
              state_d = BUF;
            end
          end
        end
        BUF: begin
          if (!stall_id) deliver = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      if (deliver) begin
        pc_d          = pc_plus4;
        id_valid_d    = 1'b1;
        id_pc_d       = pc_q;
        id_instr_d    = deliver_instr;
        id_pc_plus4_d = pc_plus4;
        // Chaining the next fetch into the delivery cycle sustains one instruction per cycle.
        if (!stall_if) begin
          issue      = 1'b1;
          fetch_addr = pc_plus4;
          state_d    = WAIT;
        end else begin
          state_d = IDLE;
        end
      end else if (!stall_id) begin
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      discard_q     <= 1'b0;
      buf_q         <= '0;
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_instr_q    <= NOP_INSTR;
      id_pc_plus4_q <= XLEN'(4);
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      discard_q     <= discard_d;
      buf_q         <= buf_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

  // The request is combinational, so it is masked while reset is held.
  assign imem_req    = issue & rst_n;
  assign imem_addr   = imem_req ? fetch_addr : '0;
  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_instr    = id_instr_q;
  assign id_pc_plus4 = id_pc_plus4_q;

`ifdef IF_STAGE_PERF_CNT_EN
  logic        drop;
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_discarded_q, perf_discarded_d;

  assign drop = redirect_valid ? ((state_q == WAIT && imem_rvalid) || state_q == BUF)
                               : (state_q == WAIT && imem_rvalid && discard_q);

  always_comb begin
    perf_fetched_d   = perf_fetched_q;
    perf_discarded_d = perf_discarded_q;
    if (deliver && perf_fetched_q != '1) perf_fetched_d = perf_fetched_q + 32'd1;
    if (drop && perf_discarded_q != '1) perf_discarded_d = perf_discarded_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q   <= '0;
      perf_discarded_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_discarded_q <= perf_discarded_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_discarded = perf_discarded_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard testbench for if_stage
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall_if, stall_id;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc, id_instr, id_pc_plus4;

  int          checks = 0;
  int          failures = 0;
  int          lat;
  int          cnt;
  logic [31:0] pend_addr;
  logic        sid_edge = 1'b0;
  logic [31:0] exp_q[$];

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_if(stall_if), .stall_id(stall_id),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_req(input string name, input logic req, input logic [31:0] addr);
    chk({name, "_req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) chk({name, "_addr"}, imem_addr, addr);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({name, "_addr"}, imem_addr, 32'd0);
    chk({name, "_id_valid"}, {31'd0, id_valid}, 32'd0);
    chk({name, "_id_pc"}, id_pc, 32'd0);
    chk({name, "_id_instr"}, id_instr, NOP);
    chk({name, "_id_pc4"}, id_pc_plus4, 32'd4);
  endtask

  always @(posedge clk) sid_edge <= stall_id;

  // Memory model: one outstanding request, response after lat cycles.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    cnt         = 0;
    pend_addr   = '0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
        end
      end
      #4;
      if (imem_req === 1'b1) begin
        pend_addr = imem_addr;
        cnt       = lat;
      end
    end
  end

  // Monitor: each newly loaded valid IF/ID entry is matched against the scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && id_valid && !sid_edge) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_delivery actual_pc=%h required=none", id_pc);
        end else begin
          e = exp_q.pop_front();
          chk("mon_pc", id_pc, e);
          chk("mon_instr", id_instr, mem_word(e));
          chk("mon_pc4", id_pc_plus4, e + 32'd4);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall_if = 1'b0; stall_id = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; lat = 1;
    repeat (2) @(negedge clk);
    #4; chk_reset("rst");

    // Streaming at 1-cycle latency, then a 2-cycle double stall at id_pc=0x8
    @(negedge clk); rst_n = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    exp_q.push_back(32'hC); exp_q.push_back(32'h10);
    #4; chk_req("r0", 1'b1, 32'h0);
    @(negedge clk); #4; chk_req("r1", 1'b1, 32'h4);
    @(negedge clk); #4; chk_req("r2", 1'b1, 32'h8);
    @(negedge clk); #4; chk_req("r3", 1'b1, 32'hC);
    @(negedge clk); stall_if = 1'b1; stall_id = 1'b1;
    #4; chk_req("r4", 1'b0, 32'h0); chk("r4_id_pc", id_pc, 32'h8);
    @(negedge clk); #4; chk_req("r5", 1'b0, 32'h0); chk("r5_id_pc", id_pc, 32'h8);
    chk("r5_id_instr", id_instr, mem_word(32'h8));
    @(negedge clk); stall_if = 1'b0; stall_id = 1'b0; #4; chk_req("r6", 1'b1, 32'h10);
    @(negedge clk); stall_if = 1'b1; #4; chk_req("r7", 1'b0, 32'h0);
    @(negedge clk);

    // 3-cycle latency, redirect one cycle after the request to 0x20
    @(negedge clk); lat = 3; redirect_valid = 1'b1; redirect_pc = 32'h23;
    @(negedge clk); redirect_valid = 1'b0; stall_if = 1'b0; #4; chk_req("s1", 1'b1, 32'h20);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h100; #4; chk_req("s2", 1'b0, 32'h0);
    @(negedge clk); redirect_valid = 1'b0; #4; chk_req("s3", 1'b0, 32'h0);
    chk("s3_id_valid", {31'd0, id_valid}, 32'd0);
    @(negedge clk); #4; chk_req("s4", 1'b0, 32'h0);
    @(negedge clk); exp_q.push_back(32'h100); #4; chk_req("s5", 1'b1, 32'h100);
    chk("s5_id_valid", {31'd0, id_valid}, 32'd0);
    @(negedge clk); stall_if = 1'b1;
    repeat (3) @(negedge clk);

    // Response to 0x4 lands in the skid buffer while decode is stalled
    lat = 1; redirect_valid = 1'b1; redirect_pc = 32'h4;
    @(negedge clk); redirect_valid = 1'b0; stall_if = 1'b0; stall_id = 1'b1;
    exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    #4; chk_req("t1", 1'b1, 32'h4);
    @(negedge clk); #4; chk_req("t2", 1'b0, 32'h0);
    @(negedge clk); stall_id = 1'b0; #4; chk_req("t3", 1'b1, 32'h8);
    @(negedge clk); stall_if = 1'b1; #4; chk("t4_id_pc", id_pc, 32'h4);
    chk("t4_id_instr", id_instr, mem_word(32'h4));

    // Redirect under both stalls
    @(negedge clk); stall_id = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    #4; chk("t5_id_valid", {31'd0, id_valid}, 32'd1);
    @(negedge clk); redirect_valid = 1'b0; #4;
    chk("t6_id_valid", {31'd0, id_valid}, 32'd0); chk("t6_id_instr", id_instr, NOP);
    chk_req("t6", 1'b0, 32'h0);
    @(negedge clk); stall_if = 1'b0; stall_id = 1'b0; exp_q.push_back(32'h200);
    #4; chk_req("t7", 1'b1, 32'h200);
    @(negedge clk); stall_if = 1'b1;

    // Reset while a request is outstanding; its late response must be ignored
    @(negedge clk); lat = 4; stall_if = 1'b0; #4; chk_req("u0", 1'b1, 32'h204);
    @(negedge clk); stall_if = 1'b1; #2; rst_n = 1'b0; #2; chk_reset("u1");
    @(negedge clk); rst_n = 1'b1; lat = 1;
    @(negedge clk);
    @(negedge clk); #4; chk_req("u4", 1'b0, 32'h0);
    @(negedge clk); stall_if = 1'b0; exp_q.push_back(32'h0);
    #4; chk("u5_id_valid", {31'd0, id_valid}, 32'd0); chk_req("u5", 1'b1, 32'h0);
    @(negedge clk); stall_if = 1'b1;

    // PC wrap, then a redirect coinciding with a response
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk); redirect_valid = 1'b0; stall_if = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h300);
    #4; chk_req("v1", 1'b1, 32'hFFFF_FFFC);
    @(negedge clk); #4; chk_req("v2", 1'b1, 32'h0);
    @(negedge clk); stall_if = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    #4; chk_req("v3", 1'b0, 32'h0);
    @(negedge clk); redirect_valid = 1'b0; stall_if = 1'b0;
    #4; chk_req("v4", 1'b1, 32'h300); chk("v4_id_valid", {31'd0, id_valid}, 32'd0);
    @(negedge clk); stall_if = 1'b1;
    repeat (3) @(negedge clk);
    #4; chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Owns the PC and issues requests to instruction memory, one outstanding at a time, with variable latency.
- Presents fetched instructions to decode.
- Obeys stall_if/stall_id from the load-use hazard unit and redirects from EX on taken branches and jumps, discarding wrong-path fetches.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on id_instr when the register holds a bubble (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_if  in  1  hazard unit: do not issue a new fetch.
- stall_id  in  1  hazard unit: IF/ID register holds its contents.
- redirect_valid  in  1  EX: taken branch/jump this cycle.
- redirect_pc  in  XLEN  EX: target address (bits [1:0] ignored, treated as 0).
- imem_req  out  1  single-cycle fetch request pulse.
- imem_addr  out  XLEN  fetch address, valid when imem_req=1.
- imem_rvalid  in  1  response strobe; returns at least 1 cycle after imem_req.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- id_valid  out  1  IF/ID holds a real instruction.
- id_pc  out  XLEN  PC of id_instr.
- id_instr  out  32  instruction to decode.
- id_pc_plus4  out  XLEN  id_pc+4, wraps modulo 2^XLEN.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, state=IDLE, discard=0, buffer empty.
  - imem_req=0, imem_addr=0.
  - id_valid=0, id_pc=0, id_instr=NOP_INSTR, id_pc_plus4=4.
- Memory contract: no grant signal, every request is accepted; at most one request outstanding; responses arrive in order.
- States:
  - IDLE: no request outstanding, buffer empty.
  - WAIT: request outstanding.
  - BUF: response captured in the 1-entry skid buffer, waiting for ID.
- IDLE: if !stall_if and !redirect_valid, drive imem_req=1, imem_addr=pc, go to WAIT.
- WAIT, on imem_rvalid:
  - discard=1: drop the word, clear discard, go to IDLE.
  - !stall_id: load IF/ID with {1, pc, rdata} and set pc=pc+4. In the same cycle, if !stall_if, issue the next request at pc+4 and stay in WAIT; otherwise go to IDLE. This gives back-to-back throughput of 1 instr/cycle at 1-cycle latency.
  - stall_id=1: store the word in the buffer, go to BUF.
- BUF:
  - When !stall_id, move the buffer into IF/ID and set pc=pc+4.
  - If !stall_if, issue the next request that same cycle and go to WAIT; otherwise go to IDLE.
- IF/ID when stall_id=1: all id_* outputs hold their values.
- IF/ID when stall_id=0 and no instruction is delivered: load a bubble (id_valid=0, id_instr=NOP_INSTR); id_pc holds.
- Redirect has the highest priority and overrides both stalls:
  - pc=redirect_pc; IF/ID becomes a bubble next cycle; buffer is emptied.
  - If a request is outstanding and its rvalid is not in this cycle, set discard=1 and stay in WAIT.
  - Otherwise go to IDLE.
  - No request is issued in the redirect cycle. The first target fetch occurs at the earliest in the following cycle.
- Redirect in the same cycle as imem_rvalid: the response is dropped, not delivered, and no discard is needed.
- A second redirect while discard=1 updates pc only; discard stays 1.
- pc+4 wraps at 2^XLEN without error.

Optional Feature:
- Macro IF_STAGE_PERF_CNT_EN.
- When defined, add two outputs:
  - perf_fetched (32 bits): counts words delivered to IF/ID.
  - perf_discarded (32 bits): counts words dropped because of a redirect.
- Both counters reset to 0, saturate at all-ones, and are independent of the stalls.
- When not defined, neither port nor any counter logic exists.

Test Plan:
- Reset release, 1-cycle memory, no stalls: imem_addr sequence 0x0,0x4,0x8. id_valid=1 from cycle 3 onward. id_pc and id_instr track the memory contents with no bubbles between them.
- stall_if=stall_id=1 for 2 cycles while id_pc=0x8: id_* outputs hold, imem_req=0. After release, the next request is at 0x10 if 0xC was already buffered, else at 0xC. No instruction is lost or duplicated.
- 3-cycle memory latency with redirect_pc=0x100 asserted 1 cycle after a request to 0x20: the 0x20 word is dropped (id_valid=0). The next imem_addr is 0x100, and the next delivered id_pc is 0x100.
- stall_id=1 when rvalid returns 0x4: word held in the buffer, no new request issued. stall_id drops the next cycle: id_instr is the buffered word and id_pc=0x4.
- Redirect with stall_if=stall_id=1: the redirect wins. id_valid=0 the next cycle, and pc becomes the target.
- rst_n asserted while in WAIT: all outputs return to reset values immediately. A late rvalid arriving after release, before the first post-reset request, is ignored.
